// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request per instruction
// to a variable-latency instruction memory, holds the fetched word until the
// core retires it, then steps to PC+4 or the ALU target. A trap is raised on
// an illegal instruction or a target that is not word-aligned.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | post-reset bubble, no request
// S_FETCH | request strobe high for one cycle, address = o_pc
// S_WAIT  | waiting for rvalid, address held
// S_READY | instruction held and valid, waiting for retire
// S_FAULT | sticky trap, only reset leaves

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic [31:0] o_instr,
    output logic        o_instr_vld,
    input  logic        i_retire,
    input  logic        i_insn_vld,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_instret
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_READY,
        S_FAULT
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic        trap;

    // Sequential successor wraps modulo 2^32.
    assign o_pc_four = o_pc + 32'd4;

    // JALR clears bit 0 of the target; bit 1 set means a misaligned target.
    assign next_pc = i_pc_sel ? (i_alu_data & 32'hFFFF_FFFE) : o_pc_four;
    assign trap    = !i_insn_vld || next_pc[1];

    // Status outputs decode directly from the state register.
    assign o_imem_req  = (state == S_FETCH);
    assign o_instr_vld = (state == S_READY);
    assign o_fault     = (state == S_FAULT);
    assign o_imem_addr = o_pc;

    // Fetch sequencing, PC update on retire and trap capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            o_pc       <= RESET_PC;
            o_instr    <= NOP;
            o_fault_pc <= '0;
            o_instret  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        o_instr <= i_imem_rdata;
                        state   <= S_READY;
                    end
                end
                S_READY: begin
                    if (i_retire) begin
                        if (trap) begin
                            o_fault_pc <= o_pc;
                            state      <= S_FAULT;
                        end else begin
                            o_pc      <= next_pc;
                            o_instret <= o_instret + 32'd1;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instructions fed through a
// memory model, expected fetch addresses queued and popped on each request,
// plus hand-written reset/wrap sequences on a second instance.

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst, rst2;

    logic        req, rvalid, vld, retire, insn_vld, pc_sel, fault;
    logic [31:0] addr, rdata, pc, pc_four, instr, alu, fault_pc, instret;

    logic        req2, rvalid2, vld2, retire2, insn_vld2, pc_sel2, fault2;
    logic [31:0] addr2, rdata2, pc2, pc_four2, instr2, alu2, fault_pc2, instret2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] exp_q[$];

    typedef struct {
        int          lat;
        logic [31:0] exp_addr;
        logic [31:0] word;
        logic        pc_sel;
        logic [31:0] alu;
        logic        insn_vld;
        logic        stray;
        logic        exp_fault;
    } vec_t;

    vec_t tbl[0:8];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset(rst),
        .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_pc(pc), .o_pc_four(pc_four), .o_instr(instr), .o_instr_vld(vld),
        .i_retire(retire), .i_insn_vld(insn_vld), .i_pc_sel(pc_sel),
        .i_alu_data(alu), .o_fault(fault), .o_fault_pc(fault_pc),
        .o_instret(instret)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .i_clk(clk), .i_reset(rst2),
        .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2),
        .o_pc(pc2), .o_pc_four(pc_four2), .o_instr(instr2), .o_instr_vld(vld2),
        .i_retire(retire2), .i_insn_vld(insn_vld2), .i_pc_sel(pc_sel2),
        .i_alu_data(alu2), .o_fault(fault2), .o_fault_pc(fault_pc2),
        .o_instret(instret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!req && n < 20) begin
            tick();
            n++;
        end
        ok = req;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got no request expected one within 20 cycles");
        end
    endtask

    task automatic run_insn(input vec_t v);
        bit          ok;
        logic [31:0] exp_a;
        logic [31:0] nxt;
        exp_q.push_back(v.exp_addr);
        wait_req(ok);
        if (!ok) begin
            void'(exp_q.pop_front());
            return;
        end
        exp_a = exp_q.pop_front();
        check("fetch_addr", addr, exp_a);
        check("fetch_pc_model", pc, m_pc);
        tick();
        for (int k = 1; k <= v.lat; k++) begin
            check1("wait_req_low", req, 1'b0);
            check("wait_addr_hold", addr, exp_a);
            check1("wait_vld_low", vld, 1'b0);
            if (k == v.lat) begin
                rvalid = 1'b1;
                rdata  = v.word;
            end
            tick();
            rvalid = 1'b0;
            rdata  = '0;
        end
        check1("ready_vld", vld, 1'b1);
        check("ready_instr", instr, v.word);
        check("ready_pc_four", pc_four, m_pc + 32'd4);
        if (v.stray) begin
            rvalid = 1'b1;
            rdata  = ~v.word;
            tick();
            rvalid = 1'b0;
            rdata  = '0;
            check("stray_instr", instr, v.word);
            check1("stray_vld", vld, 1'b1);
        end
        retire   = 1'b1;
        pc_sel   = v.pc_sel;
        alu      = v.alu;
        insn_vld = v.insn_vld;
        tick();
        retire   = 1'b0;
        pc_sel   = 1'b0;
        alu      = '0;
        insn_vld = 1'b1;
        nxt = v.pc_sel ? {v.alu[31:1], 1'b0} : m_pc + 32'd4;
        check1("fault_flag", fault, v.exp_fault);
        if (!v.insn_vld || nxt[1]) begin
            check("fault_pc", fault_pc, m_pc);
            check1("fault_vld", vld, 1'b0);
            check1("fault_req", req, 1'b0);
        end else begin
            m_pc = nxt;
            m_instret = m_instret + 32'd1;
            check("retire_pc", pc, m_pc);
            check1("retire_req", req, 1'b1);
        end
        check("instret", instret, m_instret);
    endtask

    task automatic hold_fault(input logic [31:0] exp_fpc);
        for (int k = 0; k < 4; k++) begin
            tick();
            check1("fault_no_req", req, 1'b0);
            check1("fault_sticky", fault, 1'b1);
            check1("fault_vld_low", vld, 1'b0);
        end
        check("fault_pc_hold", fault_pc, exp_fpc);
        check("fault_instret", instret, m_instret);
    endtask

    initial begin
        tbl[0] = '{1, 32'h0000_0000, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[1] = '{1, 32'h0000_0004, 32'h0020_0113, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[2] = '{1, 32'h0000_0008, 32'h0030_0193, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[3] = '{4, 32'h0000_000C, 32'h0040_0213, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0};
        tbl[4] = '{1, 32'h0000_0010, 32'h0000_00E7, 1'b1, 32'h0000_0101, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2, 32'h0000_0100, 32'h0400_0067, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
        tbl[7] = '{1, 32'h0000_0000, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[8] = '{3, 32'h0000_0004, 32'h1020_0067, 1'b1, 32'h0000_0102, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; rvalid = 1'b0; rdata = '0; retire = 1'b0;
        insn_vld = 1'b1; pc_sel = 1'b0; alu = '0;
        rst2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0; retire2 = 1'b0;
        insn_vld2 = 1'b1; pc_sel2 = 1'b0; alu2 = '0;
        m_pc = 32'h0; m_instret = 32'h0;

        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_four", pc_four, 32'h4);
        check("rst_instr", instr, NOP);
        check1("rst_vld", vld, 1'b0);
        check1("rst_req", req, 1'b0);
        check1("rst_fault", fault, 1'b0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_instret", instret, 32'h0);

        rst = 1'b0;
        check1("idle_no_req", req, 1'b0);
        tick();
        check1("first_req_second_cycle", req, 1'b1);

        for (int i = 0; i <= 6; i++) run_insn(tbl[i]);
        hold_fault(32'h0000_0040);

        #3 rst = 1'b1;
        #1;
        check("areset_pc", pc, 32'h0);
        check1("areset_fault", fault, 1'b0);
        check("areset_fault_pc", fault_pc, 32'h0);
        check("areset_instret", instret, 32'h0);
        tick();
        rst = 1'b0;
        m_pc = 32'h0; m_instret = 32'h0;
        for (int i = 7; i <= 8; i++) run_insn(tbl[i]);
        hold_fault(32'h0000_0004);

        // Wrap instance: RESET_PC at the top of the address space.
        check("w_rst_pc", pc2, 32'hFFFF_FFFC);
        tick();
        rst2 = 1'b0;
        tick();
        check1("w_req", req2, 1'b1);
        check("w_addr", addr2, 32'hFFFF_FFFC);
        check("w_pc_four", pc_four2, 32'h0000_0000);
        tick();
        rvalid2 = 1'b1;
        rdata2  = 32'h0050_0093;
        tick();
        rvalid2 = 1'b0;
        check1("w_vld", vld2, 1'b1);
        check("w_instr", instr2, 32'h0050_0093);
        retire2 = 1'b1;
        tick();
        retire2 = 1'b0;
        check1("w_req_next", req2, 1'b1);
        check("w_addr_next", addr2, 32'h0000_0000);
        check("w_instret", instret2, 32'h1);
        tick();
        check1("w_in_wait", req2, 1'b0);
        #3 rst2 = 1'b1;
        #1;
        check("w_areset_pc", pc2, 32'hFFFF_FFFC);
        check("w_areset_instr", instr2, NOP);
        check("w_areset_instret", instret2, 32'h0);
        check1("w_areset_req", req2, 1'b0);
        check1("w_areset_vld", vld2, 1'b0);
        check1("w_areset_fault", fault2, 1'b0);
        check("w_areset_fault_pc", fault_pc2, 32'h0);

        // Late rvalid across reset release must not be captured in IDLE/FETCH.
        rvalid2 = 1'b1;
        rdata2  = 32'hDEAD_BEEF;
        tick();
        rst2 = 1'b0;
        tick();
        check1("late_fetch_req", req2, 1'b1);
        tick();
        rvalid2 = 1'b0;
        rdata2  = '0;
        check("late_instr", instr2, NOP);
        check1("late_vld", vld2, 1'b0);
        tick();
        check1("late_still_wait", vld2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of the control unit. Owns the PC register and issues one request per instruction to an instruction memory with variable read latency. Holds the fetched word stable for the decode/execute path until the core retires it. Computes the next PC from the branch/jump decision and traps on misaligned targets or illegal instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- o_imem_req  out  1  fetch request strobe; one cycle per fetch.
- o_imem_addr  out  32  fetch address; equals o_pc.
- i_imem_rvalid  in  1  read data valid from instruction memory.
- i_imem_rdata  in  32  instruction word; sampled only when i_imem_rvalid=1 in WAIT.
- o_pc  out  32  PC of the held instruction.
- o_pc_four  out  32  o_pc + 4, modulo 2^32.
- o_instr  out  32  held instruction word, fed to the control unit.
- o_instr_vld  out  1  o_instr is valid and may execute this cycle.
- i_retire  in  1  core commits the held instruction this cycle.
- i_insn_vld  in  1  decode legality from the control unit for o_instr.
- i_pc_sel  in  1  0: next PC = PC+4; 1: next PC = i_alu_data.
- i_alu_data  in  32  branch/jump target from the ALU.
- o_fault  out  1  sticky trap flag.
- o_fault_pc  out  32  PC of the faulting instruction.
- o_instret  out  32  count of retired instructions.

## Operation
- States: IDLE, FETCH, WAIT, READY, FAULT.
- IDLE: entered on reset. No request is issued. Moves to FETCH on the next edge.
- FETCH: o_imem_req=1 for exactly this cycle, with o_imem_addr=o_pc. Always moves to WAIT.
- WAIT: o_imem_req=0 and o_imem_addr is held. When i_imem_rvalid=1, capture i_imem_rdata into o_instr and move to READY; otherwise stay in WAIT with no timeout.
- READY: o_instr_vld=1. The state holds until i_retire=1. On retire:
  - If i_insn_vld=0: go to FAULT, o_fault_pc<=o_pc, o_instret unchanged.
  - Otherwise compute next = i_pc_sel ? {i_alu_data[31:1],1'b0} : o_pc_four. Bit 0 is cleared to implement the JALR rule.
  - If next[1]=1: go to FAULT, o_fault_pc<=o_pc, o_instret unchanged.
  - Otherwise o_pc<=next, o_instret<=o_instret+1, go to FETCH.
- FAULT: o_fault=1 and o_instr_vld=0, with no requests issued. Only reset exits this state.
- Ignored inputs:
  - i_imem_rvalid outside WAIT.
  - i_retire outside READY.
  - i_pc_sel, i_alu_data and i_insn_vld when no retire occurs.
- Arithmetic: o_pc_four and o_instret wrap modulo 2^32. PC 32'hFFFF_FFFC sequentially advances to 32'h0000_0000.

## Timing
- Reset values (asynchronous): state=IDLE, o_pc=RESET_PC, o_instr=32'h0000_0013 (NOP), o_instr_vld=0, o_imem_req=0, o_fault=0, o_fault_pc=0, o_instret=0.
- After reset deassertion the sequence is IDLE (1 cycle), then FETCH. The first o_imem_req occurs in the second cycle after deassertion.
- Minimum throughput is 3 cycles per instruction: FETCH, WAIT with rvalid, READY with retire. Each extra memory wait cycle adds one cycle.
- o_instr, o_pc and o_pc_four are stable for the whole READY period. The PC updates on the retire edge.
- Output decoding:
  - o_imem_req and o_instr_vld decode from the state register.
  - o_pc_four is combinational from o_pc.
- Reset asserted mid-fetch (WAIT) aborts the fetch. A late i_imem_rvalid arriving after reset release, while in IDLE or FETCH, is ignored.

## Test plan
- Reset release, memory latency 1, core retires immediately: requests go to 0x0, 0x4, 0x8, and o_instret=3 after the third retire.
- Memory latency 4 cycles: o_imem_addr is held for 4 WAIT cycles, o_instr_vld rises one cycle after rvalid, and a stray rvalid in READY does not alter o_instr.
- Retire with i_pc_sel=1 and i_alu_data=0x0000_0101 (JALR odd target): the next request goes to 0x100.
- Retire with i_pc_sel=1 and i_alu_data=0x0000_0102: o_fault=1, o_fault_pc equals the old PC, no further requests, o_instret unchanged.
- Retire with i_insn_vld=0 at PC 0x40: FAULT with o_fault_pc=0x40. A subsequent i_reset returns o_pc to RESET_PC and clears o_fault.
- RESET_PC=0xFFFF_FFFC with sequential retire: the next request goes to 0x0000_0000. Asserting i_reset during WAIT yields all reset values immediately, without waiting for a clock edge.
